// File: rtl/split_func_pkg.sv
// -----------------------------------------------------------------------------
// split_func_pkg
//
// Shared definitions for the split-function encoder/decoder pair.
//
// The encoder turns one data byte d into two byte streams of equal latency:
//     a = d + OFFSET_A
//     b = (d > THRESH) ? d + OFFSET_HI : d + OFFSET_LO
// with all arithmetic modulo 256.
//
// Contents:
//     DEFAULT_*            default offsets and threshold of the encoding
//     split_dec_state_t    lock state of the receive-side decoder
//     encode_a / encode_b  encoding helpers shared by encoder and decoder
// -----------------------------------------------------------------------------
package split_func_pkg;

    localparam int DEFAULT_OFFSET_A  = 5;
    localparam int DEFAULT_OFFSET_LO = 1;
    localparam int DEFAULT_OFFSET_HI = 15;
    localparam int DEFAULT_THRESH    = 50;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } split_dec_state_t;

    // Stream a is a plain 8-bit offset of the data byte.
    function automatic logic [7:0] encode_a(
        input logic [7:0] d,
        input logic [7:0] off_a
    );
        return d + off_a;
    endfunction

    // Stream b picks its offset from an unsigned compare of the data byte
    // itself (never of the already-offset stream a value).
    function automatic logic [7:0] encode_b(
        input logic [7:0] d,
        input logic [7:0] thresh,
        input logic [7:0] off_lo,
        input logic [7:0] off_hi
    );
        logic [7:0] result;
        if (d > thresh) begin
            result = d + off_hi;
        end else begin
            result = d + off_lo;
        end
        return result;
    endfunction

endpackage

// File: rtl/split_func_dec_check.sv
// -----------------------------------------------------------------------------
// split_func_dec_check
//
// Purely combinational consistency check for one split-function sample.
// Recovers d from stream a, re-encodes it for stream b and compares with the
// received stream b byte. Also reused by the encoder's loopback checker.
//
// Ports:
//     enc_a  in   8   encoded stream a
//     enc_b  in   8   encoded stream b
//     d      out  8   recovered data byte (enc_a - OFFSET_A, mod 256)
//     ok     out  1   enc_b matches the re-encoded value of d
// -----------------------------------------------------------------------------
module split_func_dec_check
    import split_func_pkg::*;
#(
    parameter int OFFSET_A  = DEFAULT_OFFSET_A,
    parameter int OFFSET_LO = DEFAULT_OFFSET_LO,
    parameter int OFFSET_HI = DEFAULT_OFFSET_HI,
    parameter int THRESH    = DEFAULT_THRESH
) (
    input  logic [7:0] enc_a,
    input  logic [7:0] enc_b,
    output logic [7:0] d,
    output logic       ok
);

    localparam logic [7:0] OFF_A_8  = 8'(OFFSET_A);
    localparam logic [7:0] OFF_LO_8 = 8'(OFFSET_LO);
    localparam logic [7:0] OFF_HI_8 = 8'(OFFSET_HI);
    localparam logic [7:0] THRESH_8 = 8'(THRESH);

    logic [7:0] exp_b;

    // Subtraction wraps modulo 256, undoing the encoder's wrapping add.
    assign d     = enc_a - OFF_A_8;
    assign exp_b = encode_b(d, THRESH_8, OFF_LO_8, OFF_HI_8);
    assign ok    = (enc_b == exp_b);

endmodule

// File: rtl/split_func_decoder.sv
// -----------------------------------------------------------------------------
// split_func_decoder
//
// Receive side of the split-function link. Each valid sample is checked for
// consistency between streams a and b. A lock FSM (SEARCH/LOCKED) decides when
// decoded data may be trusted, and a saturating counter tallies every
// mismatching sample for the link-monitor CSR.
//
// Ports:
//     clk        in   1      rising-edge clock
//     reset      in   1      asynchronous, active-high reset
//     in_valid   in   1      enc_a/enc_b carry a sample this cycle
//     enc_a      in   8      encoded stream a
//     enc_b      in   8      encoded stream b
//     out_valid  out  1      one-cycle pulse: data_out holds a verified sample
//     data_out   out  8      decoded data, held between pulses
//     locked     out  1      FSM is in LOCKED
//     err_count  out  ERR_W  saturating total mismatch count
// -----------------------------------------------------------------------------
module split_func_decoder
    import split_func_pkg::*;
#(
    parameter int OFFSET_A   = DEFAULT_OFFSET_A,
    parameter int OFFSET_LO  = DEFAULT_OFFSET_LO,
    parameter int OFFSET_HI  = DEFAULT_OFFSET_HI,
    parameter int THRESH     = DEFAULT_THRESH,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       enc_a,
    input  logic [7:0]       enc_b,
    output logic             out_valid,
    output logic [7:0]       data_out,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    // Counters are wide enough to hold their target value itself, so the
    // incremented value can be compared against the target without overflow.
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);

    localparam logic [GOOD_W-1:0] LOCK_TGT   = GOOD_W'(LOCK_CNT);
    localparam logic [BAD_W-1:0]  UNLOCK_TGT = BAD_W'(UNLOCK_CNT);
    localparam logic [ERR_W-1:0]  ERR_MAX    = '1;

    logic [7:0]        d;
    logic              ok;

    split_dec_state_t  state;
    split_dec_state_t  state_next;
    logic [GOOD_W-1:0] good_cnt;
    logic [GOOD_W-1:0] good_cnt_next;
    logic [GOOD_W-1:0] good_inc;
    logic [BAD_W-1:0]  bad_cnt;
    logic [BAD_W-1:0]  bad_cnt_next;
    logic [BAD_W-1:0]  bad_inc;

    logic              emit;
    logic              out_valid_next;
    logic [7:0]        data_out_next;
    logic [ERR_W-1:0]  err_count_next;

    split_func_dec_check #(
        .OFFSET_A  (OFFSET_A),
        .OFFSET_LO (OFFSET_LO),
        .OFFSET_HI (OFFSET_HI),
        .THRESH    (THRESH)
    ) u_check (
        .enc_a (enc_a),
        .enc_b (enc_b),
        .d     (d),
        .ok    (ok)
    );

    assign good_inc = good_cnt + 1'b1;
    assign bad_inc  = bad_cnt + 1'b1;

    // State register. locked is registered from the next state so that it
    // changes on the very edge that performs the transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= SEARCH;
            good_cnt <= '0;
            bad_cnt  <= '0;
            locked   <= 1'b0;
        end else begin
            state    <= state_next;
            good_cnt <= good_cnt_next;
            bad_cnt  <= bad_cnt_next;
            locked   <= (state_next == LOCKED);
        end
    end

    // Next-state logic. Samples without in_valid leave every counter alone,
    // so gaps in the stream neither help nor hurt lock acquisition. Both
    // counters are cleared on every transition so each state starts fresh.
    always_comb begin
        state_next    = state;
        good_cnt_next = good_cnt;
        bad_cnt_next  = bad_cnt;
        if (in_valid) begin
            case (state)
                SEARCH: begin
                    if (ok) begin
                        if (good_inc == LOCK_TGT) begin
                            state_next    = LOCKED;
                            good_cnt_next = '0;
                            bad_cnt_next  = '0;
                        end else begin
                            good_cnt_next = good_inc;
                        end
                    end else begin
                        good_cnt_next = '0;
                    end
                end
                LOCKED: begin
                    if (ok) begin
                        bad_cnt_next = '0;
                    end else if (bad_inc == UNLOCK_TGT) begin
                        state_next    = SEARCH;
                        good_cnt_next = '0;
                        bad_cnt_next  = '0;
                    end else begin
                        bad_cnt_next = bad_inc;
                    end
                end
                default: begin
                    state_next    = SEARCH;
                    good_cnt_next = '0;
                    bad_cnt_next  = '0;
                end
            endcase
        end
    end

    // Output logic. Only a consistent sample seen while already LOCKED is
    // released, so the sample that completes lock is never emitted. The
    // mismatch counter runs in both states and sticks at its maximum.
    always_comb begin
        emit           = in_valid && ok && (state == LOCKED);
        out_valid_next = emit;
        data_out_next  = emit ? d : data_out;
        err_count_next = err_count;
        if (in_valid && !ok && (err_count != ERR_MAX)) begin
            err_count_next = err_count + 1'b1;
        end
    end

    // Output registers, giving one cycle of latency from sample to output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            err_count <= '0;
        end else begin
            out_valid <= out_valid_next;
            data_out  <= data_out_next;
            err_count <= err_count_next;
        end
    end

endmodule

// File: tb/tb_split_func_decoder.sv
// -----------------------------------------------------------------------------
// tb_split_func_decoder
//
// Directed bench for split_func_decoder. Three instances share the stimulus:
//     dut      default parameters
//     dut_sat  ERR_W=2, to see the error counter stick at 3
//     dut_one  LOCK_CNT=1 / UNLOCK_CNT=1, single-sample transitions
// Inputs change 1 time unit after a rising edge and outputs are sampled there,
// well away from the active edge.
// -----------------------------------------------------------------------------
module tb_split_func_decoder;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] enc_a;
    logic [7:0] enc_b;

    logic       out_valid;
    logic [7:0] data_out;
    logic       locked;
    logic [7:0] err_count;

    logic       sat_out_valid;
    logic [7:0] sat_data_out;
    logic       sat_locked;
    logic [1:0] sat_err_count;

    logic       one_out_valid;
    logic [7:0] one_data_out;
    logic       one_locked;
    logic [7:0] one_err_count;

    int tests_run;
    int tests_failed;

    split_func_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .out_valid (out_valid),
        .data_out  (data_out),
        .locked    (locked),
        .err_count (err_count)
    );

    split_func_decoder #(.ERR_W(2)) dut_sat (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .out_valid (sat_out_valid),
        .data_out  (sat_data_out),
        .locked    (sat_locked),
        .err_count (sat_err_count)
    );

    split_func_decoder #(.LOCK_CNT(1), .UNLOCK_CNT(1)) dut_one (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .out_valid (one_out_valid),
        .data_out  (one_data_out),
        .locked    (one_locked),
        .err_count (one_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one sample, let the DUT take it on the next rising edge and
    // return 1 time unit later so outputs are stable for checking.
    task automatic apply_stimulus(input logic v, input logic [7:0] a, input logic [7:0] b);
        in_valid = v;
        enc_a    = a;
        enc_b    = b;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        in_valid     = 1'b0;
        enc_a        = 8'd0;
        enc_b        = 8'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_out_valid", out_valid, 0);
        check_output("reset_data_out", data_out, 0);
        check_output("reset_locked", locked, 0);
        check_output("reset_err_count", err_count, 0);
        reset = 1'b0;

        // Lock: four samples of d=10 (a=15, b=11)
        apply_stimulus(1'b1, 8'd15, 8'd11);
        check_output("lock_s1_locked", locked, 0);
        check_output("one_lock_s1_locked", one_locked, 1);
        check_output("one_lock_s1_out_valid", one_out_valid, 0);
        apply_stimulus(1'b1, 8'd15, 8'd11);
        check_output("lock_s2_locked", locked, 0);
        check_output("one_lock_s2_out_valid", one_out_valid, 1);
        apply_stimulus(1'b1, 8'd15, 8'd11);
        check_output("lock_s3_locked", locked, 0);
        check_output("lock_s3_out_valid", out_valid, 0);
        apply_stimulus(1'b1, 8'd15, 8'd11);
        check_output("lock_s4_locked", locked, 1);
        check_output("lock_s4_out_valid", out_valid, 0);
        apply_stimulus(1'b1, 8'd15, 8'd11);
        check_output("first_out_valid", out_valid, 1);
        check_output("first_data_out", data_out, 10);

        // Idle cycle: pulse drops, data holds
        apply_stimulus(1'b0, 8'd99, 8'd99);
        check_output("idle_out_valid", out_valid, 0);
        check_output("idle_data_out", data_out, 10);
        check_output("idle_locked", locked, 1);

        // High branch and wrap while locked
        apply_stimulus(1'b1, 8'd65, 8'd75);
        check_output("high_d60_valid", out_valid, 1);
        check_output("high_d60_data", data_out, 60);
        apply_stimulus(1'b1, 8'd255, 8'd9);
        check_output("wrap_d250_data", data_out, 250);
        apply_stimulus(1'b1, 8'd0, 8'd10);
        check_output("wrap_d251_data", data_out, 251);
        apply_stimulus(1'b1, 8'd56, 8'd66);
        check_output("high_d51_valid", out_valid, 1);
        check_output("high_d51_data", data_out, 51);

        // Threshold boundary: d=50 takes the low offset
        apply_stimulus(1'b1, 8'd55, 8'd51);
        check_output("thresh_d50_valid", out_valid, 1);
        check_output("thresh_d50_data", data_out, 50);
        apply_stimulus(1'b1, 8'd55, 8'd65);
        check_output("thresh_bad_valid", out_valid, 0);
        check_output("thresh_bad_data_hold", data_out, 50);
        check_output("thresh_bad_err", err_count, 1);
        check_output("thresh_bad_locked", locked, 1);
        check_output("one_unlock_single_bad", one_locked, 0);

        // One bad then one good keeps lock; the good sample clears bad_cnt
        apply_stimulus(1'b1, 8'd15, 8'd11);
        check_output("recover_valid", out_valid, 1);
        check_output("recover_data", data_out, 10);
        apply_stimulus(1'b1, 8'd56, 8'd52);
        check_output("bad1_locked", locked, 1);
        check_output("bad1_err", err_count, 2);
        apply_stimulus(1'b1, 8'd55, 8'd65);
        check_output("bad2_locked", locked, 0);
        check_output("bad2_err", err_count, 3);
        check_output("bad2_valid", out_valid, 0);

        // In SEARCH: three good then one bad restarts the count
        apply_stimulus(1'b1, 8'd15, 8'd11);
        apply_stimulus(1'b1, 8'd15, 8'd11);
        apply_stimulus(1'b1, 8'd15, 8'd11);
        apply_stimulus(1'b1, 8'd15, 8'd12);
        check_output("search_bad_locked", locked, 0);
        check_output("search_bad_err", err_count, 4);
        check_output("sat_err_after_4", sat_err_count, 3);
        apply_stimulus(1'b1, 8'd15, 8'd11);
        apply_stimulus(1'b1, 8'd15, 8'd11);
        apply_stimulus(1'b1, 8'd15, 8'd11);
        check_output("search_relock_3_locked", locked, 0);
        apply_stimulus(1'b1, 8'd15, 8'd11);
        check_output("search_relock_4_locked", locked, 1);

        // Fresh start, then lock through gaps in in_valid
        reset = 1'b1;
        #2;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 8'd15, 8'd11);
            apply_stimulus(1'b0, 8'd0, 8'd0);
        end
        check_output("gap_3_locked", locked, 0);
        check_output("gap_3_out_valid", out_valid, 0);
        apply_stimulus(1'b1, 8'd15, 8'd11);
        check_output("gap_4_locked", locked, 1);
        apply_stimulus(1'b0, 8'd0, 8'd0);
        check_output("gap_idle_locked", locked, 1);
        apply_stimulus(1'b1, 8'd15, 8'd11);
        check_output("gap_out_valid", out_valid, 1);
        check_output("gap_data_out", data_out, 10);

        // Asynchronous reset mid-cycle while out_valid is high
        #3;
        reset = 1'b1;
        #1;
        check_output("async_out_valid", out_valid, 0);
        check_output("async_data_out", data_out, 0);
        check_output("async_locked", locked, 0);
        check_output("async_err_count", err_count, 0);
        check_output("async_sat_err", sat_err_count, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Saturation of the 2-bit error counter
        apply_stimulus(1'b1, 8'd15, 8'd12);
        apply_stimulus(1'b1, 8'd15, 8'd12);
        check_output("sat_err_after_2", sat_err_count, 2);
        apply_stimulus(1'b1, 8'd15, 8'd12);
        apply_stimulus(1'b1, 8'd15, 8'd12);
        apply_stimulus(1'b1, 8'd15, 8'd12);
        check_output("sat_err_after_5", sat_err_count, 3);
        check_output("wide_err_after_5", err_count, 5);

        // Relock after reset needs four fresh consistent samples
        apply_stimulus(1'b1, 8'd15, 8'd11);
        apply_stimulus(1'b1, 8'd15, 8'd11);
        apply_stimulus(1'b1, 8'd15, 8'd11);
        check_output("post_reset_3_locked", locked, 0);
        apply_stimulus(1'b1, 8'd15, 8'd11);
        check_output("post_reset_4_locked", locked, 1);
        apply_stimulus(1'b0, 8'd0, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
